// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM states and access-size helper shared by the byte-serial LSU.
package lsu_pkg;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LD = 3'b011;
    localparam logic [2:0] LBU = 3'b100, LHU = 3'b101, LWU = 3'b110;
    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010, SD = 3'b011;
    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction
endpackage

// File: rtl/lsu_byte_master_if.sv
// lsu_byte_master_if: core-side request/response and byte-wide memory port of the LSU.
interface lsu_byte_master_if #(parameter int ADDR_W = 64, parameter int XLEN = 64);
    logic              req_valid, req_ready, req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr, mem_addr;
    logic [XLEN-1:0]   req_wdata, rsp_rdata;
    logic              rsp_valid, rsp_err;
    logic [7:0]        mem_wdata, mem_rdata;
    logic              mem_we, mem_re, mem_ack;
    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we, mem_re
    );
    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: sign/zero-extends the low 1/2/4/8 bytes of the load buffer.
module lsu_load_extend #(
    parameter int XLEN = 64
) (
    input  logic [63:0]     raw,
    input  logic [1:0]      size,
    input  logic            uns,
    output logic [XLEN-1:0] data
);
    logic [63:0] mask;
    logic        sign;
    always_comb begin
        mask = size == 2'd0 ? 64'hFF : size == 2'd1 ? 64'hFFFF : size == 2'd2 ? 64'hFFFF_FFFF : '1;
        sign = ~uns & (size == 2'd0 ? raw[7] : size == 2'd1 ? raw[15] : size == 2'd2 ? raw[31] : raw[63]);
        data = XLEN'(signed'((raw & mask) | ({64{sign}} & ~mask)));
    end
endmodule

// File: rtl/lsu_byte_master.sv
// lsu_byte_master: serialises one load/store into byte beats and returns a one-cycle response.
module lsu_byte_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int XLEN        = 64,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input logic                clk,
    input logic                reset_n,
    lsu_byte_master_if.master  bus
);
    state_t          state;
    logic            we, req_bad, last;
    logic [2:0]      f3, idx, idx_n;
    logic [3:0]      req_nb;
    logic [XLEN-1:0] wdata, ext;
    logic [63:0]     rbuf, rbuf_nxt;

    always_comb begin
        req_nb   = size_bytes(bus.req_funct3[1:0]);
        req_bad  = bus.req_funct3 == 3'b111 || (bus.req_we && bus.req_funct3[2]) ||
                   (ALIGN_CHECK && (bus.req_addr[2:0] & 3'(req_nb - 4'd1)) != 3'd0);
        idx_n    = idx + 3'd1;
        last     = idx == 3'(size_bytes(f3[1:0]) - 4'd1);
        rbuf_nxt = rbuf;
        rbuf_nxt[8*idx+:8] = bus.mem_rdata;
    end

    // Fed with the buffer including the beat being acked so the response can register on the final ack.
    lsu_load_extend #(.XLEN(XLEN)) u_ext (
        .raw  (rbuf_nxt),
        .size (f3[1:0]),
        .uns  (f3[2]),
        .data (ext)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            we            <= 1'b0;
            f3            <= 3'd0;
            idx           <= 3'd0;
            wdata         <= '0;
            rbuf          <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 8'd0;
            bus.mem_we    <= 1'b0;
            bus.mem_re    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    we            <= bus.req_we;
                    f3            <= bus.req_funct3;
                    wdata         <= bus.req_wdata;
                    idx           <= 3'd0;
                    rbuf          <= '0;
                    bus.req_ready <= 1'b0;
                    bus.mem_addr  <= bus.req_addr;
                    bus.mem_wdata <= bus.req_wdata[7:0];
                    if (req_bad) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                    end else begin
                        state      <= XFER;
                        bus.mem_we <= bus.req_we;
                        bus.mem_re <= ~bus.req_we;
                    end
                end
                XFER: if (bus.mem_ack) begin
                    rbuf <= rbuf_nxt;
                    idx  <= idx_n;
                    if (last) begin
                        state         <= RESP;
                        bus.mem_we    <= 1'b0;
                        bus.mem_re    <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= we ? '0 : ext;
                    end else begin
                        bus.mem_addr  <= bus.mem_addr + 1'b1;
                        bus.mem_wdata <= wdata[8*idx_n+:8];
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_byte_master.sv
// tb_lsu_byte_master: directed tests of lsu_byte_master against a byte-memory model with ack delay.
module tb_lsu_byte_master;
    import lsu_pkg::*;
    logic clk = 1'b0, reset_n = 1'b0;
    int checks = 0, failures = 0;
    int delay = 0, wcnt = 0;
    logic [7:0] mem [256];

    always #5 clk = ~clk;

    lsu_byte_master_if #(.ADDR_W(64), .XLEN(64)) bus ();
    lsu_byte_master_if #(.ADDR_W(64), .XLEN(64)) bus2 ();

    lsu_byte_master #(.ADDR_W(64), .XLEN(64), .ALIGN_CHECK(1'b1)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    lsu_byte_master #(.ADDR_W(64), .XLEN(64), .ALIGN_CHECK(1'b0)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

    always_comb begin
        bus.mem_ack    = (bus.mem_re | bus.mem_we) && wcnt == delay;
        bus.mem_rdata  = mem[bus.mem_addr[7:0]];
        bus2.mem_ack   = bus2.mem_re | bus2.mem_we;
        bus2.mem_rdata = mem[bus2.mem_addr[7:0]];
    end

    always @(posedge clk) begin
        if (bus.mem_ack && bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        wcnt <= bus.mem_ack ? 0 : (bus.mem_re | bus.mem_we) ? wcnt + 1 : 0;
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                          output int rcyc, output logic [63:0] rd, output logic er, output int nstrobe, output logic moved);
        logic [63:0] fa;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rcyc = -1; rd = '0; er = 1'b0; nstrobe = 0; moved = 1'b0; fa = '0;
        for (int c = 1; c < 60; c++) begin
            if (bus.mem_re | bus.mem_we) begin
                if (nstrobe == 0) fa = bus.mem_addr;
                else if (bus.mem_addr != fa) moved = 1'b1;
                nstrobe++;
            end
            if (bus.rsp_valid) begin
                rcyc = c; rd = bus.rsp_rdata; er = bus.rsp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.mem_we, bus.mem_re} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {bus.rsp_valid, bus.rsp_err, bus.mem_we, bus.mem_re}); end
        checks++; if (bus.rsp_rdata !== 64'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.rsp_rdata); end
        reset_n = 1'b1;
    endtask

    task automatic test_store_sd();
        int rc, ns; logic [63:0] rd, m; logic er, mv;
        delay = 0;
        do_req(1'b1, SD, 64'h10, 64'h8877665544332211, rc, rd, er, ns, mv);
        checks++; if (rc !== 9) begin failures++; $display("FAIL sd_latency got=%0d exp=9", rc); end
        checks++; if ({er, rd} !== 65'd0) begin failures++; $display("FAIL sd_rsp got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
        checks++; if (ns !== 8) begin failures++; $display("FAIL sd_beats got=%0d exp=8", ns); end
        for (int i = 0; i < 8; i++) m[8*i+:8] = mem[8'h10 + 8'(i)];
        checks++; if (m !== 64'h8877665544332211) begin failures++; $display("FAIL sd_mem got=%h exp=8877665544332211", m); end
    endtask

    task automatic test_load_extend();
        int rc, ns; logic [63:0] rd; logic er, mv;
        do_req(1'b1, SW, 64'h10, 64'h0000FF80, rc, rd, er, ns, mv);
        checks++; if (rc !== 5) begin failures++; $display("FAIL sw_latency got=%0d exp=5", rc); end
        do_req(1'b0, LW, 64'h10, 64'h0, rc, rd, er, ns, mv);
        checks++; if (rd !== 64'h000000000000FF80 || er !== 1'b0) begin failures++; $display("FAIL lw got=%h err=%b exp=000000000000ff80 err=0", rd, er); end
        checks++; if (rc !== 5) begin failures++; $display("FAIL lw_latency got=%0d exp=5", rc); end
        do_req(1'b0, LH, 64'h10, 64'h0, rc, rd, er, ns, mv);
        checks++; if (rd !== 64'hFFFFFFFFFFFFFF80) begin failures++; $display("FAIL lh got=%h exp=ffffffffffffff80", rd); end
        do_req(1'b0, LHU, 64'h10, 64'h0, rc, rd, er, ns, mv);
        checks++; if (rd !== 64'h000000000000FF80) begin failures++; $display("FAIL lhu got=%h exp=000000000000ff80", rd); end
        do_req(1'b0, LBU, 64'h10, 64'h0, rc, rd, er, ns, mv);
        checks++; if (rd !== 64'h80) begin failures++; $display("FAIL lbu got=%h exp=80", rd); end
        do_req(1'b0, LD, 64'h10, 64'h0, rc, rd, er, ns, mv);
        checks++; if (rd !== 64'h887766550000FF80) begin failures++; $display("FAIL ld got=%h exp=887766550000ff80", rd); end
        do_req(1'b0, LWU, 64'h14, 64'h0, rc, rd, er, ns, mv);
        checks++; if (rd !== 64'h0000000088776655) begin failures++; $display("FAIL lwu got=%h exp=0000000088776655", rd); end
    endtask

    task automatic test_ack_delay();
        int rc, ns; logic [63:0] rd; logic er, mv;
        delay = 0;
        do_req(1'b1, SB, 64'h08, 64'h01, rc, rd, er, ns, mv);
        delay = 3;
        do_req(1'b0, LB, 64'h08, 64'h0, rc, rd, er, ns, mv);
        checks++; if (ns !== 4) begin failures++; $display("FAIL wait_strobe_cycles got=%0d exp=4", ns); end
        checks++; if (mv !== 1'b0) begin failures++; $display("FAIL wait_addr_stable got moved=%b exp=0", mv); end
        checks++; if (rd !== 64'h1 || rc !== 5) begin failures++; $display("FAIL wait_lb got=%h cyc=%0d exp=1 cyc=5", rd, rc); end
        delay = 0;
    endtask

    task automatic test_errors();
        int rc, ns; logic [63:0] rd; logic er, mv;
        do_req(1'b0, LW, 64'h12, 64'h0, rc, rd, er, ns, mv);
        checks++; if (rc !== 1 || er !== 1'b1 || ns !== 0 || rd !== 64'd0) begin failures++; $display("FAIL misaligned_lw got cyc=%0d err=%b beats=%0d rdata=%h exp 1/1/0/0", rc, er, ns, rd); end
        do_req(1'b1, 3'b100, 64'h10, 64'hAB, rc, rd, er, ns, mv);
        checks++; if (rc !== 1 || er !== 1'b1 || ns !== 0) begin failures++; $display("FAIL store_unsigned got cyc=%0d err=%b beats=%0d exp 1/1/0", rc, er, ns); end
        do_req(1'b0, 3'b111, 64'h0, 64'h0, rc, rd, er, ns, mv);
        checks++; if (rc !== 1 || er !== 1'b1 || ns !== 0) begin failures++; $display("FAIL funct3_111 got cyc=%0d err=%b beats=%0d exp 1/1/0", rc, er, ns); end
        checks++; if (mem[8'h10] !== 8'h80) begin failures++; $display("FAIL err_no_write got=%h exp=80", mem[8'h10]); end
    endtask

    task automatic test_reset_mid();
        int rc, ns, seen; logic [63:0] rd; logic er, mv;
        do_req(1'b1, SD, 64'h20, 64'hA7A6A5A4A3A2A1A0, rc, rd, er, ns, mv);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = SD; bus.req_addr = 64'h20; bus.req_wdata = 64'h1122334455667788;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if ({bus.mem_we, bus.mem_re} !== 2'b00) begin failures++; $display("FAIL rst_strobes got=%b exp=00", {bus.mem_we, bus.mem_re}); end
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready); end
        seen = 0;
        repeat (3) begin @(negedge clk); if (bus.rsp_valid) seen++; end
        reset_n = 1'b1;
        repeat (3) begin @(negedge clk); if (bus.rsp_valid) seen++; end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rst_no_rsp got=%0d exp=0", seen); end
        do_req(1'b0, LD, 64'h20, 64'h0, rc, rd, er, ns, mv);
        checks++; if (rd !== 64'hA7A6A5A4A3667788) begin failures++; $display("FAIL rst_partial got=%h exp=a7a6a5a4a3667788", rd); end
    endtask

    task automatic test_back_to_back();
        int c, r1, r2; logic [63:0] d1, d2; logic rdy_x, rdy_after, re_after;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = LD; bus.req_addr = 64'h10; bus.req_wdata = '0;
        c = 0; r1 = -1; r2 = -1; d1 = '0; d2 = '0; rdy_x = 1'bx; rdy_after = 1'b0; re_after = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            c++;
            if (c == 1) rdy_x = bus.req_ready;
            if (bus.rsp_valid) begin
                if (r1 < 0) begin r1 = c; d1 = bus.rsp_rdata; end
                else begin r2 = c; d2 = bus.rsp_rdata; break; end
            end
            if (r1 > 0 && c == r1 + 1) rdy_after = bus.req_ready;
            if (r1 > 0 && c == r1 + 2) begin re_after = bus.mem_re; bus.req_valid = 1'b0; end
        end
        bus.req_valid = 1'b0;
        checks++; if (rdy_x !== 1'b0) begin failures++; $display("FAIL b2b_busy_ready got=%b exp=0", rdy_x); end
        checks++; if (r1 !== 9) begin failures++; $display("FAIL b2b_first_cycle got=%0d exp=9", r1); end
        checks++; if (rdy_after !== 1'b1 || re_after !== 1'b1) begin failures++; $display("FAIL b2b_accept got ready=%b re=%b exp 1/1", rdy_after, re_after); end
        checks++; if (r2 !== 19) begin failures++; $display("FAIL b2b_second_cycle got=%0d exp=19", r2); end
        checks++; if (d1 !== 64'h887766550000FF80 || d2 !== 64'h887766550000FF80) begin failures++; $display("FAIL b2b_data got=%h,%h exp=887766550000ff80", d1, d2); end
    endtask

    task automatic test_wrap();
        int rc, ns; logic [63:0] rd, a3; logic er, mv;
        do_req(1'b1, SH, 64'hFFFF_FFFF_FFFF_FFFE, 64'hBBAA, rc, rd, er, ns, mv);
        do_req(1'b1, SH, 64'h0, 64'hDDCC, rc, rd, er, ns, mv);
        @(negedge clk);
        bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_funct3 = LW; bus2.req_addr = 64'hFFFF_FFFF_FFFF_FFFE; bus2.req_wdata = '0;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        rc = -1; rd = '0; er = 1'b1; a3 = '1;
        for (int c = 1; c < 30; c++) begin
            if (c == 3) a3 = bus2.mem_addr;
            if (bus2.rsp_valid) begin rc = c; rd = bus2.rsp_rdata; er = bus2.rsp_err; break; end
            @(negedge clk);
        end
        checks++; if (a3 !== 64'd0) begin failures++; $display("FAIL wrap_addr got=%h exp=0", a3); end
        checks++; if (rc !== 5 || er !== 1'b0) begin failures++; $display("FAIL wrap_rsp got cyc=%0d err=%b exp 5/0", rc, er); end
        checks++; if (rd !== 64'hFFFFFFFFDDCCBBAA) begin failures++; $display("FAIL wrap_data got=%h exp=ffffffffddccbbaa", rd); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0; bus.req_addr = '0; bus.req_wdata = '0;
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_funct3 = 3'd0; bus2.req_addr = '0; bus2.req_wdata = '0;
        test_reset();
        test_store_sd();
        test_load_extend();
        test_ack_delay();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
